// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the instruction-fetch requester and the data-memory
// requester share a single RAM port. Data requests have priority. A starvation
// counter forces a fetch grant after STARVE_LIMIT data grants in a row while a
// fetch is waiting. The block also holds the LL/SC link register that decides
// whether an atomic store (SC) goes ahead.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   iREN, iaddr         fetch request and address
//   iwait, iload        fetch still pending / fetched word (valid when iwait low)
//   dREN, dWEN          data read / write request (write wins if both are high)
//   datomic             marks dREN as LL and dWEN as SC
//   daddr, dstore       data address / store data
//   dwait, dload        data still pending / load data, or SC result (1 = ok)
//   link_clear          external invalidate of the link register
//   ramREN, ramWEN      RAM read / write enable
//   ramaddr, ramstore   RAM address / write data
//   ramload, ram_ready  RAM read data / RAM finishes the access this cycle
module mem_arbiter #(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic              datomic,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    input  logic              link_clear,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_ready
);

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state;
    logic [3:0]        starve_cnt;
    logic              link_valid;
    logic [WORD_W-1:0] link_addr;

    logic d_req;
    logic link_hit;
    logic grant_d;
    logic i_done;
    logic d_done;
    logic ll_done;
    logic link_kill;

    // RAM signals and responses are combinational from the current state and
    // the granted requester's live inputs. Reset forces state to IDLE, so the
    // outputs fall back to their idle values immediately.
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves a value unassigned, which would otherwise infer a latch.
        d_req     = dREN | dWEN;
        link_hit  = link_valid && (daddr == link_addr);
        grant_d   = d_req && !(iREN && (starve_cnt == LIMIT));
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iwait     = iREN;
        dwait     = d_req;
        iload     = '0;
        dload     = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        ll_done   = 1'b0;
        link_kill = 1'b0;

        unique case (state)
            IGNT: begin
                // A withdrawn fetch leaves the enables low and the FSM exits.
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_ready) begin
                        iwait  = 1'b0;
                        iload  = ramload;
                        i_done = 1'b1;
                    end
                end
            end
            DGNT: begin
                if (dWEN) begin
                    if (datomic && !link_hit) begin
                        // SC fail: answer at once, RAM untouched.
                        dwait  = 1'b0;
                        d_done = 1'b1;
                    end else begin
                        ramWEN   = 1'b1;
                        ramaddr  = daddr;
                        ramstore = dstore;
                        if (ram_ready) begin
                            dwait     = 1'b0;
                            d_done    = 1'b1;
                            // SC success reports 1; a plain store reports 0.
                            dload     = {{(WORD_W-1){1'b0}}, datomic};
                            link_kill = link_hit;
                        end
                    end
                end else if (dREN) begin
                    ramREN  = 1'b1;
                    ramaddr = daddr;
                    if (ram_ready) begin
                        dwait   = 1'b0;
                        dload   = ramload;
                        d_done  = 1'b1;
                        ll_done = datomic;
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        state <= DGNT;
                        if (iREN && starve_cnt < LIMIT)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (iREN) begin
                        state      <= IGNT;
                        starve_cnt <= '0;
                    end
                end
                IGNT:    if (i_done || !iREN) state <= IDLE;
                DGNT:    if (d_done || !d_req) state <= IDLE;
                default: state <= IDLE;
            endcase

            // A completing LL beats a simultaneous invalidate.
            if (ll_done) begin
                link_valid <= 1'b1;
                link_addr  <= daddr;
            end else if (link_clear || link_kill) begin
                link_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. Contains a word-array
// RAM, a table of single-access vectors, hand-written multi-cycle sequences
// (reset, simultaneous requests, starvation, LL/SC) and a randomized phase
// checked against a transaction-level model (memory image plus link state).
module tb_mem_arbiter;

    localparam int W     = 32;
    localparam int LIMIT = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         iREN;
    logic [W-1:0] iaddr;
    logic         iwait;
    logic [W-1:0] iload;
    logic         dREN;
    logic         dWEN;
    logic         datomic;
    logic [W-1:0] daddr;
    logic [W-1:0] dstore;
    logic         dwait;
    logic [W-1:0] dload;
    logic         link_clear;
    logic         ramREN;
    logic         ramWEN;
    logic [W-1:0] ramaddr;
    logic [W-1:0] ramstore;
    logic [W-1:0] ramload;
    logic         ram_ready;

    logic [W-1:0] ram   [256];
    logic [W-1:0] m_mem [256];

    int n_pass    = 0;
    int n_total   = 0;
    int wen_count = 0;

    assign ramload = ram[ramaddr[9:2]];

    always #5 CLK = ~CLK;

    mem_arbiter #(.WORD_W(W), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr),
        .dstore(dstore), .dwait(dwait), .dload(dload),
        .link_clear(link_clear),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready)
    );

    typedef struct {
        logic [3:0]   req;     // {iREN, dREN, dWEN, datomic}
        logic [W-1:0] ia, da, ds;
        logic [3:0]   c0;      // {ramREN, ramWEN, iwait, dwait} in IDLE cycle
        logic [3:0]   c1;      // same, one cycle later with ram_ready high
        logic [W-1:0] addr, store, il, dl;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [W-1:0] init_word(input int idx);
        return 32'hA500_0000 + 32'(idx) * 32'h11;
    endfunction

    function automatic logic [W-1:0] pick_addr();
        return 32'h100 + 32'($urandom_range(0, 3)) * 32'd4;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // Commit any RAM write of the current cycle, then move to 1 after the edge.
    task automatic tick();
        if (ramWEN && ram_ready) begin
            ram[ramaddr[9:2]] = ramstore;
            wen_count++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic add_vec(input logic [3:0] req, input logic [W-1:0] ia, da, ds,
                           input logic [3:0] c0, c1,
                           input logic [W-1:0] addr, store, il, dl);
        vec_t v;
        v.req = req; v.ia = ia; v.da = da; v.ds = ds; v.c0 = c0; v.c1 = c1;
        v.addr = addr; v.store = store; v.il = il; v.dl = dl;
        vecs.push_back(v);
    endtask

    task automatic drop_all();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0; link_clear = 1'b0;
    endtask

    // One data access starting in an IDLE cycle; lat counts cycles from it.
    task automatic d_access(input logic wen, ren, atm, input logic [W-1:0] addr, data,
                            input logic rdy, output logic [W-1:0] ld, output int lat);
        dWEN = wen; dREN = ren; datomic = atm; daddr = addr; dstore = data; ram_ready = rdy;
        lat = -1;
        ld  = '0;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (!dwait) begin
                lat = c;
                ld  = dload;
                break;
            end
            tick();
        end
        check_bit("d_access_done", lat >= 0, 1'b1);
        if (lat >= 0) tick();
        dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ld;
        int           lat;
        int           w0;
        int           n;
        logic         order[6];
        logic         link_v;
        logic [W-1:0] link_a;
        logic         i_done, d_done, ll_now, sc_ok;
        int           streak, i_cnt, d_cnt, kind;

        // ---------------- reset ----------------
        RST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; link_clear = 1'b0; ram_ready = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = init_word(i);
        #2;
        check_bit("rst_ramREN", ramREN, 1'b0);
        check_bit("rst_ramWEN", ramWEN, 1'b0);
        check_bit("rst_iwait", iwait, 1'b1);
        check_bit("rst_dwait", dwait, 1'b0);
        check("rst_iload", iload, '0);
        iREN = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;

        // Reset in the middle of a data grant.
        dREN = 1'b1; daddr = 32'h40;
        #2;
        check_bit("mid_idle_ramREN", ramREN, 1'b0);
        tick(); #2;
        check_bit("mid_dgnt_ramREN", ramREN, 1'b1);
        check("mid_dgnt_ramaddr", ramaddr, 32'h40);
        RST = 1'b1;
        #1;
        check_bit("mid_rst_ramREN", ramREN, 1'b0);
        check("mid_rst_ramaddr", ramaddr, '0);
        check_bit("mid_rst_dwait", dwait, 1'b1);
        dREN = 1'b0;
        tick();
        RST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            check("idle_enables", {30'b0, ramREN, ramWEN}, '0);
            tick();
        end

        // ---------------- single-access vector table ----------------
        add_vec(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        add_vec(4'b1000, 32'h10, 0, 0, 4'b0010, 4'b1000, 32'h10, 0, init_word(4), 0);
        add_vec(4'b0100, 0, 32'h20, 0, 4'b0001, 4'b1000, 32'h20, 0, 0, init_word(8));
        add_vec(4'b0010, 0, 32'h30, 32'h1234, 4'b0001, 4'b0100, 32'h30, 32'h1234, 0, 0);
        add_vec(4'b0110, 0, 32'h34, 32'h5678, 4'b0001, 4'b0100, 32'h34, 32'h5678, 0, 0);
        add_vec(4'b1100, 32'h14, 32'h24, 0, 4'b0011, 4'b1010, 32'h24, 0, 0, init_word(9));
        add_vec(4'b1000, 32'h18, 0, 0, 4'b0010, 4'b1000, 32'h18, 0, init_word(6), 0);
        add_vec(4'b0011, 0, 32'h38, 32'h99, 4'b0001, 4'b0000, 0, 0, 0, 0);
        add_vec(4'b0101, 0, 32'h3C, 0, 4'b0001, 4'b1000, 32'h3C, 0, 0, init_word(15));

        foreach (vecs[k]) begin
            {iREN, dREN, dWEN, datomic} = vecs[k].req;
            iaddr = vecs[k].ia; daddr = vecs[k].da; dstore = vecs[k].ds; ram_ready = 1'b1;
            #2;
            check($sformatf("v%0d_c0_ctl", k), {28'b0, ramREN, ramWEN, iwait, dwait}, {28'b0, vecs[k].c0});
            tick(); #2;
            check($sformatf("v%0d_c1_ctl", k), {28'b0, ramREN, ramWEN, iwait, dwait}, {28'b0, vecs[k].c1});
            check($sformatf("v%0d_ramaddr", k), ramaddr, vecs[k].addr);
            check($sformatf("v%0d_ramstore", k), ramstore, vecs[k].store);
            check($sformatf("v%0d_iload", k), iload, vecs[k].il);
            check($sformatf("v%0d_dload", k), dload, vecs[k].dl);
            tick();
            drop_all();
        end
        check("v3_ram", ram[12], 32'h1234);

        // ---------------- simultaneous requests ----------------
        iREN = 1'b1; iaddr = 32'h50; dREN = 1'b1; daddr = 32'h60; ram_ready = 1'b1;
        #2;
        check("sim_c0", {29'b0, iwait, dwait, ramREN}, 32'b110);
        tick(); #2;
        check_bit("sim_c1_dwait", dwait, 1'b0);
        check_bit("sim_c1_iwait", iwait, 1'b1);
        check("sim_c1_dload", dload, init_word(24));
        tick();
        check("sim_starve_1", 32'(dut.starve_cnt), 32'd1);
        dREN = 1'b0;
        #2;
        check("sim_c2", {30'b0, iwait, ramREN}, 32'b10);
        tick(); #2;
        check_bit("sim_c3_iwait", iwait, 1'b0);
        check("sim_c3_iload", iload, init_word(20));
        tick();
        check("sim_starve_0", 32'(dut.starve_cnt), 32'd0);
        drop_all();
        tick();

        // ---------------- starvation ----------------
        iREN = 1'b1; iaddr = 32'h70; dREN = 1'b1; daddr = 32'h74; ram_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            #2;
            if (!dwait) begin order[n] = 1'b1; n++; end
            else if (!iwait) begin order[n] = 1'b0; n++; end
            tick();
        end
        check("starve_grants", n, 6);
        for (int k = 0; k < 6; k++)
            check_bit($sformatf("starve_order_%0d", k), order[k], (k != LIMIT));
        drop_all();
        tick(); tick();

        // ---------------- LL/SC ----------------
        d_access(1'b0, 1'b1, 1'b1, 32'h100, 0, 1'b1, ld, lat);
        check("ll_load", ld, init_word(64));
        w0 = wen_count;
        d_access(1'b1, 1'b0, 1'b1, 32'h100, 32'hDEAD, 1'b1, ld, lat);
        check("sc_ok_dload", ld, 32'd1);
        check("sc_ok_wen", wen_count - w0, 1);
        check("sc_ok_ram", ram[64], 32'hDEAD);
        check_bit("sc_ok_link", dut.link_valid, 1'b0);

        d_access(1'b0, 1'b1, 1'b1, 32'h100, 0, 1'b1, ld, lat);
        d_access(1'b1, 1'b0, 1'b0, 32'h100, 32'h5555, 1'b1, ld, lat);
        w0 = wen_count;
        d_access(1'b1, 1'b0, 1'b1, 32'h100, 32'hBEEF, 1'b0, ld, lat);
        check("scf1_dload", ld, '0);
        check("scf1_lat", lat, 1);
        check("scf1_wen", wen_count - w0, 0);
        check("scf1_ram", ram[64], 32'h5555);

        d_access(1'b0, 1'b1, 1'b1, 32'h100, 0, 1'b1, ld, lat);
        d_access(1'b1, 1'b0, 1'b1, 32'h104, 32'hCAFE, 1'b0, ld, lat);
        check("scf2_dload", ld, '0);
        check("scf2_ram", ram[65], init_word(65));

        link_clear = 1'b1;
        d_access(1'b0, 1'b1, 1'b1, 32'h200, 0, 1'b1, ld, lat);
        link_clear = 1'b0;
        check_bit("llclr_link", dut.link_valid, 1'b1);
        d_access(1'b1, 1'b0, 1'b1, 32'h200, 32'h77, 1'b1, ld, lat);
        check("llclr_sc", ld, 32'd1);
        check("llclr_ram", ram[128], 32'h77);

        d_access(1'b0, 1'b1, 1'b1, 32'h200, 0, 1'b1, ld, lat);
        link_clear = 1'b1;
        tick();
        link_clear = 1'b0;
        d_access(1'b1, 1'b0, 1'b1, 32'h200, 32'h88, 1'b0, ld, lat);
        check("clr_sc", ld, '0);

        // ---------------- randomized against a transaction model ----------------
        RST = 1'b1;
        #1;
        RST = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = ram[i];
        link_v = 1'b0; link_a = '0;
        streak = 0; i_cnt = 0; d_cnt = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!iREN && $urandom_range(0, 2) == 0) begin
                iREN = 1'b1; iaddr = pick_addr();
            end
            if (!(dREN || dWEN) && $urandom_range(0, 1) == 0) begin
                kind    = int'($urandom_range(0, 3));
                dREN    = (kind == 0 || kind == 2);
                dWEN    = (kind == 1 || kind == 3);
                datomic = (kind >= 2);
                daddr   = pick_addr();
                dstore  = $urandom;
            end
            ram_ready  = ($urandom_range(0, 2) != 0);
            link_clear = ($urandom_range(0, 7) == 0);
            #2;
            i_done = iREN && !iwait;
            d_done = (dREN || dWEN) && !dwait;
            ll_now = 1'b0;
            if (i_done) begin
                check("rnd_iload", iload, m_mem[iaddr[9:2]]);
                i_cnt++;
                streak = 0;
            end
            if (d_done) begin
                d_cnt++;
                if (iREN) begin
                    streak++;
                    check_bit("rnd_starve_bound", streak <= LIMIT + 1, 1'b1);
                end
                if (dWEN) begin
                    sc_ok = link_v && (link_a == daddr);
                    if (datomic) begin
                        check("rnd_sc", dload, {31'b0, sc_ok});
                        if (sc_ok) begin
                            m_mem[daddr[9:2]] = dstore;
                            link_v = 1'b0;
                        end
                    end else begin
                        m_mem[daddr[9:2]] = dstore;
                        if (sc_ok) link_v = 1'b0;
                    end
                end else begin
                    check("rnd_dload", dload, m_mem[daddr[9:2]]);
                    if (datomic) begin
                        link_v = 1'b1; link_a = daddr; ll_now = 1'b1;
                    end
                end
            end
            if (link_clear && !ll_now) link_v = 1'b0;
            tick();
            if (i_done) iREN = 1'b0;
            if (d_done) begin dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0; end
        end
        drop_all();
        check_bit("rnd_progress", (i_cnt > 20) && (d_cnt > 20), 1'b1);
        for (int i = 64; i < 68; i++)
            check($sformatf("rnd_mem_%0d", i), ram[i], m_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
